bus_switch: RTL and testbench

- Parametrised single-master to N-slave bus switch that replaces hand-written select/mux chains in SoC tops.
- Decodes the CPU bus address against per-slave base/size windows and forwards the transaction, with the address rebased, to exactly one slave.
- Registers the slave response back to the master.
- Adds a bus timeout and an unmapped-address error response, so a bad access never hangs the CPU; latches the faulting address for debug.

---
 rtl/bus_switch_if.sv | 35 +++
 rtl/bus_switch.sv | 215 +++++++++++++++++++++
 tb/tb_bus_switch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_switch_if.sv
// Bus bundle between the CPU master, the switch and the NSLAVES slave ports.
// Signal names keep the i_/o_ direction prefixes as seen from the switch.
interface bus_switch_if #(
  parameter int NSLAVES = 8
);
  logic                    i_request;
  logic                    i_rw;
  logic [31:0]             i_address;
  logic [31:0]             i_wdata;
  logic [31:0]             o_rdata;
  logic                    o_ready;
  logic                    o_error;
  logic [NSLAVES-1:0]      o_slave_request;
  logic                    o_slave_rw;
  logic [31:0]             o_slave_address;
  logic [31:0]             o_slave_wdata;
  logic [NSLAVES*32-1:0]   i_slave_rdata;
  logic [NSLAVES-1:0]      i_slave_ready;
  logic [31:0]             o_fault_address;
  logic [15:0]             o_fault_count;

  // Switch side.
  modport slave (
    input  i_request, i_rw, i_address, i_wdata, i_slave_rdata, i_slave_ready,
    output o_rdata, o_ready, o_error, o_slave_request, o_slave_rw,
           o_slave_address, o_slave_wdata, o_fault_address, o_fault_count
  );

  // CPU and slave-port side.
  modport master (
    output i_request, i_rw, i_address, i_wdata, i_slave_rdata, i_slave_ready,
    input  o_rdata, o_ready, o_error, o_slave_request, o_slave_rw,
           o_slave_address, o_slave_wdata, o_fault_address, o_fault_count
  );
endinterface

// File: rtl/bus_switch.sv
// Single-master to NSLAVES-slave bus switch: window decode with address
// rebasing, registered response, bus timeout, unmapped-address error
// completion and a fault address / saturating fault counter for debug.
module bus_switch #(
  parameter int                      NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0]   SLAVE_BASE    = '0,
  parameter logic [NSLAVES*32-1:0]   SLAVE_SIZE    = '0,
  parameter int unsigned             TIMEOUT       = 1024,
  parameter logic [31:0]             DEFAULT_RDATA = 32'h0000_0000
) (
  input logic         i_clock,
  input logic         i_reset_n,
  bus_switch_if.slave bus
);

  localparam int          SEL_W        = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [31:0]         wait_cnt_q;
  logic                ready_q;
  logic                error_q;
  logic [31:0]         rdata_q;
  logic [NSLAVES-1:0]  slave_req_q;
  logic                slave_rw_q;
  logic [31:0]         slave_addr_q;
  logic [31:0]         slave_wdata_q;
  logic [31:0]         fault_addr_q;
  logic [15:0]         fault_cnt_q;

  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;
  logic [NSLAVES-1:0]  hit_onehot;
  logic [31:0]         hit_offset;
  logic [31:0]         offset_k;

  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;

  logic                ev_accept;
  logic                ev_unmapped;
  logic                ev_slave_done;
  logic                ev_timeout;
  logic                ev_abort;
  logic                ev_release;
  logic                ev_error;

  // Fault counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address decode: walk from the top index down so the lowest hitting index wins.
  // The unsigned 32-bit offset compare keeps windows ending at 4 GiB correct.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    hit_offset = '0;
    offset_k   = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      offset_k = bus.i_address - SLAVE_BASE[k*32 +: 32];
      if ((SLAVE_SIZE[k*32 +: 32] != 32'd0) &&
          (bus.i_address >= SLAVE_BASE[k*32 +: 32]) &&
          (offset_k < SLAVE_SIZE[k*32 +: 32])) begin
        hit_any        = 1'b1;
        hit_idx        = SEL_W'(k);
        hit_onehot     = '0;
        hit_onehot[k]  = 1'b1;
        hit_offset     = offset_k;
      end
    end
  end

  // Response mux for the latched slave; other slaves' ready/data never reach the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ready = bus.i_slave_ready[k];
        sel_rdata = bus.i_slave_rdata[k*32 +: 32];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_LAST);

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state and transition events; a master dropping request wins over ready.
  always_comb begin
    state_d       = state_q;
    ev_accept     = 1'b0;
    ev_unmapped   = 1'b0;
    ev_slave_done = 1'b0;
    ev_timeout    = 1'b0;
    ev_abort      = 1'b0;
    ev_release    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_request) begin
          if (hit_any) begin
            state_d   = ST_ACTIVE;
            ev_accept = 1'b1;
          end else begin
            state_d     = ST_DONE;
            ev_unmapped = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!bus.i_request) begin
          state_d  = ST_IDLE;
          ev_abort = 1'b1;
        end else if (sel_ready) begin
          state_d       = ST_DONE;
          ev_slave_done = 1'b1;
        end else if (timeout_hit) begin
          state_d    = ST_DONE;
          ev_timeout = 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.i_request) begin
          state_d    = ST_IDLE;
          ev_release = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ev_error = ev_unmapped | ev_timeout;

  // Slave-side request: latch the decoded transaction, drop it on any exit from ACTIVE.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_q         <= '0;
      slave_req_q   <= '0;
      slave_rw_q    <= 1'b0;
      slave_addr_q  <= '0;
      slave_wdata_q <= '0;
    end else if (ev_accept) begin
      sel_q         <= hit_idx;
      slave_req_q   <= hit_onehot;
      slave_rw_q    <= bus.i_rw;
      slave_addr_q  <= hit_offset;
      slave_wdata_q <= bus.i_wdata;
    end else if (ev_slave_done || ev_timeout || ev_abort) begin
      slave_req_q   <= '0;
    end
  end

  // Wait counter: zero on the first ACTIVE cycle, counts every ACTIVE cycle after.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                wait_cnt_q <= '0;
    else if (ev_accept)            wait_cnt_q <= '0;
    else if (state_q == ST_ACTIVE) wait_cnt_q <= wait_cnt_q + 32'd1;
  end

  // Master-side completion; rdata keeps its last value after the master releases.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else if (ev_slave_done) begin
      ready_q <= 1'b1;
      error_q <= 1'b0;
      rdata_q <= sel_rdata;
    end else if (ev_error) begin
      ready_q <= 1'b1;
      error_q <= 1'b1;
      rdata_q <= DEFAULT_RDATA;
    end else if (ev_release) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end
  end

  // Fault log: capture the offending address and count every error completion.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else if (ev_error) begin
      fault_addr_q <= bus.i_address;
      fault_cnt_q  <= sat_inc16(fault_cnt_q);
    end
  end

  assign bus.o_rdata         = rdata_q;
  assign bus.o_ready         = ready_q;
  assign bus.o_error         = error_q;
  assign bus.o_slave_request = slave_req_q;
  assign bus.o_slave_rw      = slave_rw_q;
  assign bus.o_slave_address = slave_addr_q;
  assign bus.o_slave_wdata   = slave_wdata_q;
  assign bus.o_fault_address = fault_addr_q;
  assign bus.o_fault_count   = fault_cnt_q;

endmodule

// File: tb/tb_bus_switch.sv
// Scoreboard bench for bus_switch: four slave windows (two overlapping, one
// disabled), 16-cycle timeout, non-zero default error read data.
module tb_bus_switch;

  localparam int NS = 4;
  localparam logic [NS*32-1:0] BASES = {32'h4000_0000, 32'h0000_0080, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] SIZES = {32'h0000_0000, 32'h0000_0100, 32'h0001_0000, 32'h0001_0000};
  localparam logic [31:0]      DEF_RD = 32'hBADC_0DE5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bus_switch_if #(.NSLAVES(NS)) bus();

  bus_switch #(
    .NSLAVES       (NS),
    .SLAVE_BASE    (BASES),
    .SLAVE_SIZE    (SIZES),
    .TIMEOUT       (16),
    .DEFAULT_RDATA (DEF_RD)
  ) dut (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_fcnt  = 16'd0;
  logic [31:0] exp_faddr = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new completion is matched against the oldest queued expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.o_ready === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion: got rdata %h err %b, expected no completion",
                   bus.o_rdata, bus.o_error);
        end else begin
          e = exp_q.pop_front();
          check("sb_rdata", bus.o_rdata, e.rdata);
          check("sb_error", 32'(bus.o_error), 32'(e.err));
        end
      end
      prev = (bus.o_ready === 1'b1);
    end
  end

  task automatic idle_bus();
    bus.i_request     = 1'b0;
    bus.i_rw          = 1'b0;
    bus.i_address     = '0;
    bus.i_wdata       = '0;
    bus.i_slave_ready = '0;
    bus.i_slave_rdata = '0;
  endtask

  // Every slave except sel shouts ready with junk data.
  task automatic set_decoys(input int sel);
    for (int k = 0; k < NS; k++) begin
      if (k != sel) begin
        bus.i_slave_ready[k]         = 1'b1;
        bus.i_slave_rdata[k*32 +: 32] = 32'h0BAD_0000 + 32'(k);
      end
    end
  endtask

  task automatic wait_ready(input string tag, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clock); #1;
      if (bus.o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_wait_ready: got no o_ready within %0d cycles, expected completion", tag, max_cycles);
    end
  endtask

  task automatic release_master(input string tag, input logic [31:0] held_rdata);
    idle_bus();
    @(posedge clock); #1;
    check({tag, "_ready_clr"}, 32'(bus.o_ready), 32'd0);
    check({tag, "_error_clr"}, 32'(bus.o_error), 32'd0);
    check({tag, "_rdata_hold"}, bus.o_rdata, held_rdata);
  endtask

  task automatic run_mapped(input string tag, input logic [31:0] addr, input logic rw,
                            input logic [31:0] wd, input int sel, input logic [31:0] exp_off,
                            input int delay, input logic [31:0] srd);
    bit ok;
    exp_q.push_back('{rdata: srd, err: 1'b0});
    bus.i_request = 1'b1;
    bus.i_rw      = rw;
    bus.i_address = addr;
    bus.i_wdata   = wd;
    set_decoys(sel);
    @(posedge clock); #1;
    check({tag, "_slave_req"},  32'(bus.o_slave_request), 32'(1 << sel));
    check({tag, "_slave_addr"}, bus.o_slave_address, exp_off);
    check({tag, "_slave_rw"},   32'(bus.o_slave_rw), 32'(rw));
    check({tag, "_slave_wd"},   bus.o_slave_wdata, wd);
    repeat (delay) begin
      @(posedge clock); #1;
    end
    check({tag, "_no_early_ready"}, 32'(bus.o_ready), 32'd0);
    bus.i_slave_ready[sel]          = 1'b1;
    bus.i_slave_rdata[sel*32 +: 32] = srd;
    wait_ready(tag, 4, ok);
    check({tag, "_req_drop"}, 32'(bus.o_slave_request), 32'd0);
    check({tag, "_fault_cnt"}, 32'(bus.o_fault_count), 32'(exp_fcnt));
    release_master(tag, srd);
  endtask

  task automatic log_error(input logic [31:0] addr);
    exp_faddr = addr;
    if (exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
  endtask

  task automatic run_unmapped(input string tag, input logic [31:0] addr);
    exp_q.push_back('{rdata: DEF_RD, err: 1'b1});
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b0;
    bus.i_address = addr;
    set_decoys(-1);
    @(posedge clock); #1;
    log_error(addr);
    check({tag, "_ready"},      32'(bus.o_ready), 32'd1);
    check({tag, "_no_req"},     32'(bus.o_slave_request), 32'd0);
    check({tag, "_fault_addr"}, bus.o_fault_address, exp_faddr);
    check({tag, "_fault_cnt"},  32'(bus.o_fault_count), 32'(exp_fcnt));
    release_master(tag, DEF_RD);
  endtask

  task automatic run_timeout(input string tag, input logic [31:0] addr);
    int  cnt;
    bit  ok;
    exp_q.push_back('{rdata: DEF_RD, err: 1'b1});
    bus.i_request = 1'b1;
    bus.i_address = addr;
    set_decoys(0);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock); #1;
      if (bus.o_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.o_slave_request[0] === 1'b1) cnt++;
    end
    log_error(addr);
    check({tag, "_completed"},  32'(ok), 32'd1);
    check({tag, "_req_cycles"}, 32'(cnt), 32'd16);
    check({tag, "_req_drop"},   32'(bus.o_slave_request), 32'd0);
    check({tag, "_fault_addr"}, bus.o_fault_address, exp_faddr);
    check({tag, "_fault_cnt"},  32'(bus.o_fault_count), 32'(exp_fcnt));
    release_master(tag, DEF_RD);
  endtask

  task automatic run_abort(input string tag);
    bus.i_request = 1'b1;
    bus.i_address = 32'h0001_0008;
    @(posedge clock); #1;
    check({tag, "_slave_req"}, 32'(bus.o_slave_request), 32'b0010);
    bus.i_request = 1'b0;
    @(posedge clock); #1;
    check({tag, "_req_drop"}, 32'(bus.o_slave_request), 32'd0);
    bus.i_slave_ready[1] = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    check({tag, "_no_ready"},  32'(bus.o_ready), 32'd0);
    check({tag, "_fault_cnt"}, 32'(bus.o_fault_count), 32'(exp_fcnt));
    idle_bus();
    @(posedge clock); #1;
  endtask

  task automatic run_reset_mid(input string tag);
    bus.i_request = 1'b1;
    bus.i_address = 32'h0000_0020;
    @(posedge clock); #1;
    check({tag, "_slave_req"}, 32'(bus.o_slave_request), 32'b0001);
    reset_n = 1'b0;
    #1;
    exp_fcnt  = 16'd0;
    exp_faddr = 32'd0;
    check({tag, "_req_clr"},    32'(bus.o_slave_request), 32'd0);
    check({tag, "_addr_clr"},   bus.o_slave_address, 32'd0);
    check({tag, "_no_ready"},   32'(bus.o_ready), 32'd0);
    check({tag, "_fault_cnt"},  32'(bus.o_fault_count), 32'(exp_fcnt));
    idle_bus();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check({tag, "_idle_ready"}, 32'(bus.o_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, expected earlier end");
    $fatal(1);
  end

  initial begin
    idle_bus();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",      32'(bus.o_ready), 32'd0);
    check("rst_error",      32'(bus.o_error), 32'd0);
    check("rst_rdata",      bus.o_rdata, 32'd0);
    check("rst_slave_req",  32'(bus.o_slave_request), 32'd0);
    check("rst_slave_rw",   32'(bus.o_slave_rw), 32'd0);
    check("rst_slave_addr", bus.o_slave_address, 32'd0);
    check("rst_slave_wd",   bus.o_slave_wdata, 32'd0);
    check("rst_fault_addr", bus.o_fault_address, 32'd0);
    check("rst_fault_cnt",  32'(bus.o_fault_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_mapped("rd_s1",      32'h0001_0004, 1'b0, 32'h0,          1, 32'h0000_0004, 2, 32'hDEAD_BEEF);
    run_unmapped("unmapped", 32'h3000_0000);
    run_timeout("timeout",   32'h0000_0020);
    run_mapped("overlap",    32'h0000_0100, 1'b0, 32'h0,          0, 32'h0000_0100, 0, 32'h1234_5678);
    run_mapped("s1_last",    32'h0001_FFFF, 1'b0, 32'h0,          1, 32'h0000_FFFF, 1, 32'hA5A5_5A5A);
    run_unmapped("s1_end",   32'h0002_0000);
    run_unmapped("top_addr", 32'hFFFF_FFF0);
    run_unmapped("size0",    32'h4000_0000);
    run_mapped("write",      32'h0000_1234, 1'b1, 32'hCAFE_F00D, 0, 32'h0000_1234, 1, 32'h1111_1111);
    run_abort("abort");
    run_mapped("post_abort", 32'h0001_0010, 1'b0, 32'h0,          1, 32'h0000_0010, 0, 32'h0F0F_0F0F);
    run_reset_mid("rst_mid");
    run_mapped("post_rst",   32'h0000_0040, 1'b0, 32'h0,          0, 32'h0000_0040, 1, 32'h7777_0001);

    force dut.fault_cnt_q = 16'hFFFE;
    #1;
    release dut.fault_cnt_q;
    exp_fcnt = 16'hFFFE;
    @(posedge clock); #1;
    check("sat_preload", 32'(bus.o_fault_count), 32'(exp_fcnt));
    run_unmapped("sat_reach", 32'h5000_0000);
    run_unmapped("sat_hold",  32'h5000_0004);

    repeat (4) @(posedge clock);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
